// File: rtl/n64adv_vout_stage.sv
// Final video output stage: registers syncs, aligns colors to syncs through a
// programmable delay line, optionally blanks colors, gates composite syncs and
// drives the filter/VGA-sync jumper pins. Configuration is shadowed and only
// takes effect at a VSYNC falling edge (or on the first cycle after reset).
module n64adv_vout_stage #(
    parameter int COLOR_W   = 8,
    parameter int N_CH      = 3,
    parameter int MAX_DELAY = 4,
    parameter int N_CSYNC   = 2,
    localparam int DW       = $clog2(MAX_DELAY),
    localparam int CW       = N_CH * COLOR_W
) (
    input  logic                 VCLK,
    input  logic                 VRST,
    input  logic [CW+3:0]        vdata_i,
    input  logic [DW-1:0]        cfg_delay_i,
    input  logic [N_CSYNC-1:0]   cfg_csync_en_i,
    input  logic [2:0]           cfg_filter_i,
    input  logic [1:0]           cfg_linemult_i,
    input  logic                 cfg_blank_en_i,
    input  logic                 use_vga_hvsync_i,
    output logic [CW-1:0]        VD_o,
    output logic [N_CSYNC-1:0]   nCSYNC,
    output logic                 nVSYNC_or_F2,
    output logic                 nHSYNC_or_F1,
    output logic                 cfg_applied_o,
    output logic [1:0]           filter_o
);

    // Input split: Sync[3:0] = {nVSYNC, nCLAMP/nBLANK, nHSYNC, nCSYNC}
    logic [3:0]          sync_in_s;
    logic [CW-1:0]       color_in_s;

    // Frame-boundary detection and shadow configuration
    logic                vsync_q,    vsync_d;
    logic                pending_q,  pending_d;
    logic                applied_q,  applied_d;
    logic [DW-1:0]       delay_q,    delay_d;
    logic [N_CSYNC-1:0]  csync_en_q, csync_en_d;
    logic [2:0]          filt_cfg_q, filt_cfg_d;
    logic [1:0]          linemult_q, linemult_d;
    logic                blank_en_q, blank_en_d;
    logic                vsync_fall_s;
    logic                load_s;

    // Color delay line; the output register itself is the last stage, so
    // tap 0 is the live input and tap k is line entry k-1.
    logic [CW-1:0]       line_q [MAX_DELAY-1];
    logic [CW-1:0]       line_d [MAX_DELAY-1];
    logic [CW-1:0]       taps_s [MAX_DELAY];

    // Output registers
    logic [CW-1:0]       vd_q,       vd_d;
    logic [N_CSYNC-1:0]  ncsync_q,   ncsync_d;
    logic                f2_q,       f2_d;
    logic                f1_q,       f1_d;
    logic [1:0]          filter_q,   filter_d;
    logic [1:0]          code_s;

    assign sync_in_s  = vdata_i[CW+3:CW];
    assign color_in_s = vdata_i[CW-1:0];

    // Next-state logic for shadow config, delay line and all output registers
    always_comb begin
        vsync_d      = sync_in_s[3];
        vsync_fall_s = vsync_q & ~sync_in_s[3];
        load_s       = pending_q | vsync_fall_s;
        pending_d    = 1'b0;
        applied_d    = load_s;

        if (load_s) begin
            delay_d    = cfg_delay_i;
            csync_en_d = cfg_csync_en_i;
            filt_cfg_d = cfg_filter_i;
            linemult_d = cfg_linemult_i;
            blank_en_d = cfg_blank_en_i;
        end else begin
            delay_d    = delay_q;
            csync_en_d = csync_en_q;
            filt_cfg_d = filt_cfg_q;
            linemult_d = linemult_q;
            blank_en_d = blank_en_q;
        end

        line_d[0] = color_in_s;
        for (int k = 1; k < MAX_DELAY - 1; k++) begin
            line_d[k] = line_q[k-1];
        end

        taps_s[0] = color_in_s;
        for (int k = 1; k < MAX_DELAY; k++) begin
            taps_s[k] = line_q[k-1];
        end

        // Blank decision follows the sync that is registered alongside VD_o
        if (blank_en_q && !sync_in_s[2]) begin
            vd_d = '0;
        end else begin
            vd_d = taps_s[delay_q];
        end

        // Auto filter follows line-multiplier mode; fixed settings are offset by one
        if (filt_cfg_q == 3'd0) begin
            code_s = linemult_q;
        end else begin
            code_s = filt_cfg_q[1:0] - 2'd1;
        end
        filter_d = code_s;

        ncsync_d = {N_CSYNC{sync_in_s[0]}} & csync_en_q;

        if (use_vga_hvsync_i) begin
            f2_d = sync_in_s[3];
            f1_d = sync_in_s[1];
        end else begin
            f2_d = code_s[0];
            f1_d = code_s[1];
        end
    end

    // State and output registers with synchronous reset; pending forces a load after reset
    always_ff @(posedge VCLK) begin
        if (VRST) begin
            vsync_q    <= 1'b0;
            pending_q  <= 1'b1;
            applied_q  <= 1'b0;
            delay_q    <= '0;
            csync_en_q <= '0;
            filt_cfg_q <= 3'd0;
            linemult_q <= 2'd0;
            blank_en_q <= 1'b0;
            for (int k = 0; k < MAX_DELAY - 1; k++) begin
                line_q[k] <= '0;
            end
            vd_q       <= '0;
            ncsync_q   <= '0;
            f2_q       <= 1'b0;
            f1_q       <= 1'b0;
            filter_q   <= 2'd0;
        end else begin
            vsync_q    <= vsync_d;
            pending_q  <= pending_d;
            applied_q  <= applied_d;
            delay_q    <= delay_d;
            csync_en_q <= csync_en_d;
            filt_cfg_q <= filt_cfg_d;
            linemult_q <= linemult_d;
            blank_en_q <= blank_en_d;
            for (int k = 0; k < MAX_DELAY - 1; k++) begin
                line_q[k] <= line_d[k];
            end
            vd_q       <= vd_d;
            ncsync_q   <= ncsync_d;
            f2_q       <= f2_d;
            f1_q       <= f1_d;
            filter_q   <= filter_d;
        end
    end

    assign VD_o          = vd_q;
    assign nCSYNC        = ncsync_q;
    assign nVSYNC_or_F2  = f2_q;
    assign nHSYNC_or_F1  = f1_q;
    assign cfg_applied_o = applied_q;
    assign filter_o      = filter_q;

endmodule

// File: tb/tb_n64adv_vout_stage.sv
// Directed self-checking bench for n64adv_vout_stage (default parameters).
module tb_n64adv_vout_stage;

    logic        VCLK;
    logic        VRST;
    logic [27:0] vdata_i;
    logic [1:0]  cfg_delay_i;
    logic [1:0]  cfg_csync_en_i;
    logic [2:0]  cfg_filter_i;
    logic [1:0]  cfg_linemult_i;
    logic        cfg_blank_en_i;
    logic        use_vga_hvsync_i;
    logic [23:0] VD_o;
    logic [1:0]  nCSYNC;
    logic        nVSYNC_or_F2;
    logic        nHSYNC_or_F1;
    logic        cfg_applied_o;
    logic [1:0]  filter_o;

    int          checks;
    int          failures;
    int          ec;
    logic [7:0]  hist [256];
    logic [7:0]  cur_col;
    logic [7:0]  col;

    n64adv_vout_stage dut (
        .VCLK             (VCLK),
        .VRST             (VRST),
        .vdata_i          (vdata_i),
        .cfg_delay_i      (cfg_delay_i),
        .cfg_csync_en_i   (cfg_csync_en_i),
        .cfg_filter_i     (cfg_filter_i),
        .cfg_linemult_i   (cfg_linemult_i),
        .cfg_blank_en_i   (cfg_blank_en_i),
        .use_vga_hvsync_i (use_vga_hvsync_i),
        .VD_o             (VD_o),
        .nCSYNC           (nCSYNC),
        .nVSYNC_or_F2     (nVSYNC_or_F2),
        .nHSYNC_or_F1     (nHSYNC_or_F1),
        .cfg_applied_o    (cfg_applied_o),
        .filter_o         (filter_o)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    // Expected color word for a pixel whose channel 0 is c
    function automatic logic [23:0] col3(input logic [7:0] c);
        return {c, c + 8'd1, c + 8'd2};
    endfunction

    task automatic drive(input logic [3:0] s, input logic [7:0] c);
        vdata_i = {s, c, c + 8'd1, c + 8'd2};
        cur_col = c;
    endtask

    // One active edge; remembers which color was presented at that edge
    task automatic tick();
        hist[ec[7:0]] = cur_col;
        @(posedge VCLK);
        #1;
        ec = ec + 1;
    endtask

    // Color captured at the edge that lies d edges before the latest one
    function automatic logic [23:0] exp_vd(input int d);
        int idx;
        idx = ec - 1 - d;
        return col3(hist[idx[7:0]]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run a VSYNC falling edge: one cycle with Sync[3]=0, then back to idle sync
    task automatic vsync_pulse(input logic [7:0] c);
        drive(4'h7, c);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ec       = 0;
        col      = 8'h10;
        cur_col  = 8'h00;

        // ---------------- reset state ----------------
        VRST             = 1'b1;
        cfg_delay_i      = 2'd2;
        cfg_csync_en_i   = 2'b11;
        cfg_filter_i     = 3'd0;
        cfg_linemult_i   = 2'd0;
        cfg_blank_en_i   = 1'b0;
        use_vga_hvsync_i = 1'b0;
        drive(4'h0, 8'h00);
        tick();
        tick();
        chk("rst_vd",      32'(VD_o),          32'h0);
        chk("rst_ncsync",  32'(nCSYNC),        32'h0);
        chk("rst_f2",      32'(nVSYNC_or_F2),  32'h0);
        chk("rst_f1",      32'(nHSYNC_or_F1),  32'h0);
        chk("rst_filter",  32'(filter_o),      32'h0);
        chk("rst_applied", 32'(cfg_applied_o), 32'h0);

        // ---------------- delay alignment, d = 2 ----------------
        VRST = 1'b0;
        drive(4'hF, col);
        tick();
        chk("post_rst_applied", 32'(cfg_applied_o), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            col = col + 8'd1;
            drive({3'b111, i[0]}, col);
            tick();
            if (i == 1) chk("post_rst_applied_clr", 32'(cfg_applied_o), 32'h0);
            if (i >= 3) chk("d2_vd", 32'(VD_o), 32'(exp_vd(2)));
            chk("d2_ncsync", 32'(nCSYNC), 32'({2{i[0]}}));
        end
        chk("d2_filter", 32'(filter_o), 32'h0);

        // ---------------- frame-boundary shadowing ----------------
        cfg_delay_i = 2'd0;
        col = col + 8'd1;
        vsync_pulse(col);
        chk("vs0_applied", 32'(cfg_applied_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            col = col + 8'd1;
            drive(4'hF, col);
            tick();
            if (i == 0) chk("vs0_applied_clr", 32'(cfg_applied_o), 32'h0);
            chk("d0_vd", 32'(VD_o), 32'(exp_vd(0)));
        end
        cfg_delay_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            col = col + 8'd1;
            drive(4'hF, col);
            tick();
            chk("d0_hold_vd", 32'(VD_o), 32'(exp_vd(0)));
            chk("d0_hold_applied", 32'(cfg_applied_o), 32'h0);
        end
        col = col + 8'd1;
        vsync_pulse(col);
        chk("vs3_applied", 32'(cfg_applied_o), 32'h1);
        chk("vs3_edge_vd", 32'(VD_o), 32'(exp_vd(0)));
        for (int i = 0; i < 5; i++) begin
            col = col + 8'd1;
            drive(4'hF, col);
            tick();
            if (i == 0) chk("vs3_applied_clr", 32'(cfg_applied_o), 32'h0);
            chk("d3_vd", 32'(VD_o), 32'(exp_vd(3)));
        end

        // ---------------- blanking ----------------
        cfg_delay_i    = 2'd0;
        cfg_blank_en_i = 1'b1;
        vsync_pulse(8'hAA);
        drive(4'hF, 8'hAA);
        tick();
        chk("blank_pre_vd", 32'(VD_o), 32'(col3(8'hAA)));
        for (int i = 0; i < 5; i++) begin
            drive(4'hB, 8'hAA);
            tick();
            chk("blank_on_vd", 32'(VD_o), 32'h0);
        end
        drive(4'hF, 8'hAA);
        tick();
        chk("blank_post_vd", 32'(VD_o), 32'(col3(8'hAA)));
        cfg_blank_en_i = 1'b0;
        vsync_pulse(8'hAA);
        for (int i = 0; i < 3; i++) begin
            drive(4'hB, 8'hAA);
            tick();
            chk("blank_off_vd", 32'(VD_o), 32'(col3(8'hAA)));
        end

        // ---------------- filter and jumper ----------------
        cfg_filter_i   = 3'd0;
        cfg_linemult_i = 2'd2;
        vsync_pulse(col);
        drive(4'hF, col);
        tick();
        chk("auto_filter", 32'(filter_o),     32'h2);
        chk("auto_f2",     32'(nVSYNC_or_F2), 32'h0);
        chk("auto_f1",     32'(nHSYNC_or_F1), 32'h1);
        cfg_filter_i = 3'd1;
        vsync_pulse(col);
        drive(4'hF, col);
        tick();
        chk("fix1_filter", 32'(filter_o),     32'h0);
        chk("fix1_f2",     32'(nVSYNC_or_F2), 32'h0);
        chk("fix1_f1",     32'(nHSYNC_or_F1), 32'h0);
        cfg_filter_i = 3'd4;
        vsync_pulse(col);
        drive(4'hF, col);
        tick();
        chk("fix4_filter", 32'(filter_o),     32'h3);
        chk("fix4_f2",     32'(nVSYNC_or_F2), 32'h1);
        chk("fix4_f1",     32'(nHSYNC_or_F1), 32'h1);
        use_vga_hvsync_i = 1'b1;
        drive(4'hD, col);
        tick();
        chk("vga_a_f2", 32'(nVSYNC_or_F2), 32'h1);
        chk("vga_a_f1", 32'(nHSYNC_or_F1), 32'h0);
        drive(4'h7, col);
        tick();
        chk("vga_b_f2", 32'(nVSYNC_or_F2), 32'h0);
        chk("vga_b_f1", 32'(nHSYNC_or_F1), 32'h1);
        drive(4'hF, col);
        tick();
        use_vga_hvsync_i = 1'b0;

        // ---------------- csync gating ----------------
        cfg_csync_en_i = 2'b10;
        vsync_pulse(col);
        drive(4'hF, col);
        tick();
        chk("csync_a", 32'(nCSYNC), 32'h2);
        drive(4'hE, col);
        tick();
        chk("csync_b", 32'(nCSYNC), 32'h0);
        drive(4'hF, col);
        tick();
        chk("csync_c", 32'(nCSYNC), 32'h2);

        // ---------------- reset mid-frame, coincident with a vsync edge ----------------
        cfg_delay_i = 2'd3;
        vsync_pulse(col);
        for (int i = 0; i < 2; i++) begin
            col = col + 8'd1;
            drive(4'hF, col);
            tick();
        end
        VRST = 1'b1;
        drive(4'h7, col);
        tick();
        chk("mid_rst_vd",      32'(VD_o),          32'h0);
        chk("mid_rst_ncsync",  32'(nCSYNC),        32'h0);
        chk("mid_rst_f2",      32'(nVSYNC_or_F2),  32'h0);
        chk("mid_rst_f1",      32'(nHSYNC_or_F1),  32'h0);
        chk("mid_rst_filter",  32'(filter_o),      32'h0);
        chk("mid_rst_applied", 32'(cfg_applied_o), 32'h0);
        VRST = 1'b0;
        drive(4'hF, col);
        tick();
        chk("mid_rel_applied", 32'(cfg_applied_o), 32'h1);
        chk("mid_rel_filter",  32'(filter_o),      32'h0);
        drive(4'hF, col);
        tick();
        chk("mid_rel_applied_clr", 32'(cfg_applied_o), 32'h0);
        chk("mid_rel_filter_new",  32'(filter_o),      32'h3);
        chk("mid_rel_ncsync",      32'(nCSYNC),        32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
